// File: rtl/logic_unit_seq.sv
// rtl/logic_unit_seq.sv - registered eight-function bitwise logic unit with scan mode
// Optional feature macro: LOGIC_PARITY_EN (registered even parity on out_par)
module logic_unit_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_op,
  output logic             out_last,
  output logic             out_par,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state, state_next;
  logic [2:0]       cnt, cnt_next;
  logic [WIDTH-1:0] lat_a, lat_b;
  logic             accept, hs;
  logic             load, latch, clear_valid, load_last;
  logic [2:0]       load_code;
  logic [WIDTH-1:0] src_a, src_b, result;

  function automatic logic [WIDTH-1:0] func(input logic [2:0] code,
                                            input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y);
    case (code)
      3'd0:    func = ~x;
      3'd1:    func = x;
      3'd2:    func = ~(x ^ y);
      3'd3:    func = x ^ y;
      3'd4:    func = x | y;
      3'd5:    func = ~(x | y);
      3'd6:    func = x & y;
      default: func = ~(x & y);
    endcase
  endfunction

  assign hs = out_valid && out_ready;

  // Next-state, handshake and output-register load decisions
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    in_ready    = 1'b0;
    accept      = 1'b0;
    load        = 1'b0;
    latch       = 1'b0;
    clear_valid = 1'b0;
    load_code   = op;
    load_last   = 1'b1;
    src_a       = a;
    src_b       = b;
    case (state)
      IDLE: begin
        in_ready = !out_valid || out_ready;
        accept   = in_valid && in_ready;
        if (accept) begin
          load = 1'b1;
          if (!mode) begin
            load_code = op;
            load_last = 1'b1;
          end else begin
            // The first scan result comes from the live operands, which are
            // the same values being latched on this edge.
            latch      = 1'b1;
            cnt_next   = 3'd0;
            load_code  = 3'd0;
            load_last  = 1'b0;
            state_next = SCAN;
          end
        end else if (hs) begin
          clear_valid = 1'b1;
        end
      end
      SCAN: begin
        src_a = lat_a;
        src_b = lat_b;
        if (hs) begin
          if (cnt != 3'd7) begin
            cnt_next  = cnt + 3'd1;
            load      = 1'b1;
            load_code = cnt + 3'd1;
            load_last = (cnt == 3'd6);
          end else begin
            clear_valid = 1'b1;
            state_next  = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    result = func(load_code, src_a, src_b);
  end

  // State and scan counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Output register and latched scan operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_op    <= 3'd0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      lat_a     <= '0;
      lat_b     <= '0;
    end else begin
      if (latch) begin
        lat_a <= a;
        lat_b <= b;
      end
      if (load) begin
        out_data  <= result;
        out_op    <= load_code;
        out_last  <= load_last;
        out_valid <= 1'b1;
      end else if (clear_valid) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef LOGIC_PARITY_EN
  // Parity travels with out_data so it always describes the held result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_par <= 1'b0;
    end else if (load) begin
      out_par <= ^result;
    end
  end
`else
  assign out_par = 1'b0;
`endif

endmodule

// File: tb/tb_logic_unit_seq.sv
// tb/tb_logic_unit_seq.sv - directed self-checking bench for logic_unit_seq
module tb_logic_unit_seq;

  logic       clk;
  logic       rst;
  logic [7:0] a, b;
  logic [2:0] op;
  logic       mode;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic [2:0] out_op;
  logic       out_last;
  logic       out_par;
  logic       out_valid;
  logic       out_ready;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Hand-computed results for a=F0, b=3C, indexed by function code
  logic [7:0] exp_tab [8];

  logic exp_par_one;

  logic_unit_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .op        (op),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_op    (out_op),
    .out_last  (out_last),
    .out_par   (out_par),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total_cnt++;
    if ({out_valid, out_data, out_op, out_last, out_par, in_ready} !== {1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_state got v=%b d=%h op=%0d l=%b p=%b r=%b exp v=0 d=00 op=0 l=0 p=0 r=1",
               out_valid, out_data, out_op, out_last, out_par, in_ready);
    else pass_cnt++;
    rst = 1'b0;
    step();
    total_cnt++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL reset_release got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_single();
    a = 8'hF0; b = 8'h3C; mode = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      op = 3'(k); in_valid = 1'b1;
      #1;
      total_cnt++;
      if (in_ready !== 1'b1)
        $display("FAIL single_in_ready k=%0d got %b exp 1", k, in_ready);
      else pass_cnt++;
      step();
      total_cnt++;
      if ({out_valid, out_op, out_last, out_data} !== {1'b1, 3'(k), 1'b1, exp_tab[k]})
        $display("FAIL single k=%0d got v=%b op=%0d l=%b d=%h exp v=1 op=%0d l=1 d=%h",
                 k, out_valid, out_op, out_last, out_data, k, exp_tab[k]);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    step();
    total_cnt++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL single_drain got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_scan();
    a = 8'hF0; b = 8'h3C; mode = 1'b1; op = 3'd5; out_ready = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      total_cnt++;
      if ({out_valid, out_op, out_last, out_data, in_ready} !== {1'b1, 3'(k), (k == 7), exp_tab[k], 1'b0})
        $display("FAIL scan k=%0d got v=%b op=%0d l=%b d=%h r=%b exp v=1 op=%0d l=%0d d=%h r=0",
                 k, out_valid, out_op, out_last, out_data, in_ready, k, (k == 7), exp_tab[k]);
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL scan_gap got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    a = 8'hF0; b = 8'h3C; mode = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if ({out_valid, out_op, out_data} !== {1'b1, 3'd0, 8'h0F})
      $display("FAIL bp_first got v=%b op=%0d d=%h exp v=1 op=0 d=0f", out_valid, out_op, out_data);
    else pass_cnt++;
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    a = 8'h00;
    mode = 1'b0;
    for (int s = 0; s < 5; s++) begin
      step();
      total_cnt++;
      if ({out_valid, out_op, out_data, in_ready} !== {1'b1, 3'd2, 8'h33, 1'b0})
        $display("FAIL bp_hold s=%0d got v=%b op=%0d d=%h r=%b exp v=1 op=2 d=33 r=0",
                 s, out_valid, out_op, out_data, in_ready);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    for (int k = 3; k < 8; k++) begin
      step();
      total_cnt++;
      if ({out_valid, out_op, out_last, out_data} !== {1'b1, 3'(k), (k == 7), exp_tab[k]})
        $display("FAIL bp_resume k=%0d got v=%b op=%0d l=%b d=%h exp v=1 op=%0d l=%0d d=%h",
                 k, out_valid, out_op, out_last, out_data, k, (k == 7), exp_tab[k]);
      else pass_cnt++;
    end
    step();
    total_cnt++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL bp_end got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_scan();
    a = 8'hF0; b = 8'h3C; mode = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    total_cnt++;
    if ({out_valid, out_op, out_data} !== {1'b1, 3'd3, 8'hCC})
      $display("FAIL rst_pre got v=%b op=%0d d=%h exp v=1 op=3 d=cc", out_valid, out_op, out_data);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({out_valid, out_data, out_op, out_last, in_ready} !== {1'b0, 8'h00, 3'd0, 1'b0, 1'b1})
      $display("FAIL rst_mid got v=%b d=%h op=%0d l=%b r=%b exp v=0 d=00 op=0 l=0 r=1",
               out_valid, out_data, out_op, out_last, in_ready);
    else pass_cnt++;
    step();
    rst = 1'b0;
    step();
    total_cnt++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL rst_no_resume got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
    else pass_cnt++;
    mode = 1'b0; op = 3'd4; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if ({out_valid, out_op, out_last, out_data} !== {1'b1, 3'd4, 1'b1, 8'hFC})
      $display("FAIL rst_after_single got v=%b op=%0d l=%b d=%h exp v=1 op=4 l=1 d=fc",
               out_valid, out_op, out_last, out_data);
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid !== 1'b0)
      $display("FAIL rst_after_drain got v=%b exp 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_parity();
    a = 8'h01; b = 8'h00; op = 3'd1; mode = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if ({out_valid, out_data, out_par} !== {1'b1, 8'h01, exp_par_one})
      $display("FAIL parity got v=%b d=%h p=%b exp v=1 d=01 p=%b", out_valid, out_data, out_par, exp_par_one);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b0)
      $display("FAIL stall_in_ready got %b exp 0", in_ready);
    else pass_cnt++;
    out_ready = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1)
      $display("FAIL comb_in_ready got %b exp 1", in_ready);
    else pass_cnt++;
    op = 3'd0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if ({out_valid, out_data, out_par} !== {1'b1, 8'hFE, exp_par_one})
      $display("FAIL parity_fe got v=%b d=%h p=%b exp v=1 d=fe p=%b", out_valid, out_data, out_par, exp_par_one);
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid !== 1'b0)
      $display("FAIL parity_drain got v=%b exp 0", out_valid);
    else pass_cnt++;
  endtask

  initial begin
    exp_tab[0] = 8'h0F; exp_tab[1] = 8'hF0; exp_tab[2] = 8'h33; exp_tab[3] = 8'hCC;
    exp_tab[4] = 8'hFC; exp_tab[5] = 8'h03; exp_tab[6] = 8'h30; exp_tab[7] = 8'hCF;
`ifdef LOGIC_PARITY_EN
    exp_par_one = 1'b1;
`else
    exp_par_one = 1'b0;
`endif
    rst = 1'b1; a = '0; b = '0; op = '0; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step();
    step();
    test_reset();
    test_single();
    test_scan();
    test_backpressure();
    test_reset_mid_scan();
    test_parity();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
